// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory; sub-word stores use read-modify-write.
// Optional: define MAU_TRACE_EN to print every memory write as "@pc: *addr <= data".
module mem_access_unit #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata
);

    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;
    logic [31:0] merge_q;

    logic        accept;
    logic        req_err;
    logic        mem_active;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (64'(req_addr) >= BYTE_LIMIT) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = DONE;
                    end else if (!req_write) begin
                        state_next = LOAD;
                    end else if (req_size == 2'b10) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_READ;
                    end
                end
            end
            LOAD:     state_next = DONE;
            RMW_READ: state_next = WRITE;
            WRITE:    state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Little-endian lane extraction for loads; the half lane is picked by addr[1].
    always_comb begin
        load_byte = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
        load_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size)
            2'b00:   load_data = {{24{!lat_unsigned && load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{!lat_unsigned && load_half[15]}}, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        store_data = merge_q;
        case (lat_size)
            2'b00:   store_data[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            2'b01:   store_data[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: store_data = lat_wdata;
        endcase
    end

    // Response fields change only on the edge that enters DONE, so they hold between responses.
    always_ff @(posedge clk) begin
        if (Reset) begin
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_pc       <= '0;
            merge_q      <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            if (accept) begin
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_pc       <= req_pc;
                if (req_err) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
            case (state)
                LOAD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                RMW_READ: merge_q <= mem_rdata;
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_active = (state == LOAD) || (state == RMW_READ) || (state == WRITE);
    assign mem_addr   = mem_active ? {lat_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (state == WRITE) ? store_data : 32'h0;
    assign mem_we     = (state == WRITE) && lat_write && !Reset;
    assign mem_pc     = (state != IDLE) ? lat_pc : 32'h0;
    assign resp_valid = (state == DONE);

`ifdef MAU_TRACE_EN
    always @(posedge clk) begin
        if (mem_we && !Reset) begin
            $display("@%h: *%h <= %h", mem_pc, mem_addr, mem_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus random requests against an
// arithmetic reference model of the load/store rules and a model of memory contents.
module tb_mem_access_unit;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam logic [31:0] BYTE_LIMIT  = 32'(4 * DEPTH_WORDS);

    logic        clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    logic [31:0] bmem    [DEPTH_WORDS];
    logic [31:0] ref_mem [DEPTH_WORDS];

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_pc      (req_pc),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_pc      (mem_pc),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = bmem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            bmem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decides error, load value, latency and the stored word from the access rules alone.
    task automatic ref_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic e, output logic [31:0] rd, output int lat,
                              output logic [31:0] nw);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] old;
        logic [31:0] mask;
        e   = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
              (sz == 2'd2 && addr % 4 != 0) || (addr >= BYTE_LIMIT);
        rd  = 32'h0;
        nw  = 32'h0;
        lat = 1;
        if (e) return;
        idx  = addr / 4;
        old  = ref_mem[idx];
        sh   = (addr % 4) * 8;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!wr) begin
            rd = (old >> sh) & mask;
            if (!uns && sz == 2'd0 && rd >= 32'd128)   rd = rd | ~mask;
            if (!uns && sz == 2'd1 && rd >= 32'd32768) rd = rd | ~mask;
            lat = 2;
        end else begin
            nw = (old & ~(mask << sh)) | ((wdata & mask) << sh);
            ref_mem[idx] = nw;
            lat = (sz == 2'd2) ? 2 : 3;
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        logic        e;
        logic [31:0] rd;
        logic [31:0] nw;
        int          lat;
        int          cyc;
        int          we_cnt;
        int          n;
        logic        got;
        logic [31:0] we_addr;
        logic [31:0] we_data;
        logic [31:0] pc_seen;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_ready_wait"}, 32'(req_ready), 32'h1);
            return;
        end
        ref_access(wr, sz, uns, addr, wdata, e, rd, lat, nw);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = pc;
        @(posedge clk);
        cyc     = 0;
        we_cnt  = 0;
        got     = 1'b0;
        we_addr = 32'h0;
        we_data = 32'h0;
        pc_seen = 32'h0;
        while (cyc < 8 && !got) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (cyc == 1 || mem_pc !== pc) pc_seen = mem_pc;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (resp_valid) got = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_err"}, 32'(resp_err), 32'(e));
        check({tag, "_rdata"}, resp_rdata, rd);
        check({tag, "_mem_pc"}, pc_seen, pc);
        check({tag, "_we_count"}, 32'(we_cnt), (wr && !e) ? 32'd1 : 32'd0);
        if (wr && !e) begin
            check({tag, "_we_addr"}, we_addr, {addr[31:2], 2'b00});
            check({tag, "_we_data"}, we_data, nw);
            check({tag, "_mem_word"}, bmem[addr[11:2]], ref_mem[addr[11:2]]);
        end
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(req_ready), 32'h1);
    endtask

    logic [31:0] exp_rd_q[$];
    logic        exp_err_q[$];

    initial begin
        logic [31:0] w;
        logic        e;
        logic [31:0] rd;
        logic [31:0] nw;
        logic [31:0] addr;
        logic [31:0] old;
        int          lat;
        int          n_acc;
        int          n_resp;

        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            w          = $urandom;
            bmem[i]    = w;
            ref_mem[i] = w;
        end
        Reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_pc       = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_pc", mem_pc, 32'h0);
        Reset = 1'b0;

        // Directed cases from the plan.
        do_req("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h100);
        check("sw_10_word", bmem[4], 32'hDEADBEEF);
        do_req("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h104);
        check("lb_13_value", resp_rdata, 32'hFFFFFFDE);
        do_req("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h108);
        do_req("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h10C);
        do_req("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h110);
        do_req("sb_11",  1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 32'h114);
        do_req("sh_12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 32'h118);
        check("sh_12_word", bmem[4], 32'h123455EF);
        do_req("lw_06_mis",   1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h11C);
        do_req("sh_05_mis",   1'b1, 2'b01, 1'b0, 32'h05, 32'hAAAA, 32'h120);
        do_req("sw_1000_oor", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h1, 32'h124);
        do_req("size11",      1'b1, 2'b11, 1'b0, 32'h08, 32'h1, 32'h128);
        do_req("lw_last",     1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'h12C);

        // Reset during WRITE: the word store must not land and no response may follow.
        @(negedge clk);
        old          = bmem[8];
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b10;
        req_addr     = 32'h20;
        req_wdata    = 32'hCAFEF00D;
        req_pc       = 32'h200;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        Reset     = 1'b1;
        #1;
        check("rstw_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        Reset = 1'b0;
        check("rstw_ready", 32'(req_ready), 32'h1);
        check("rstw_resp_valid", 32'(resp_valid), 32'h0);
        check("rstw_mem_addr", mem_addr, 32'h0);
        check("rstw_mem_pc", mem_pc, 32'h0);
        check("rstw_word", bmem[8], old);

        // Back-to-back: req_valid held high, alternating LW/SW on the same word.
        n_acc  = 0;
        n_resp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                n_resp++;
                if (exp_rd_q.size() == 0) begin
                    check("b2b_extra_resp", 32'h1, 32'h0);
                end else begin
                    check("b2b_rdata", resp_rdata, exp_rd_q.pop_front());
                    check("b2b_err", 32'(resp_err), 32'(exp_err_q.pop_front()));
                end
            end
            req_valid    = 1'b1;
            req_write    = (i % 2 == 1);
            req_size     = 2'b10;
            req_unsigned = 1'b0;
            req_addr     = 32'h40;
            req_wdata    = 32'h1000_0000 + 32'(i);
            req_pc       = 32'h300 + 32'(i);
            if (req_ready) begin
                n_acc++;
                ref_access(req_write, req_size, req_unsigned, req_addr, req_wdata, e, rd, lat, nw);
                exp_rd_q.push_back(rd);
                exp_err_q.push_back(e);
            end
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                n_resp++;
                if (exp_rd_q.size() == 0) begin
                    check("b2b_extra_resp", 32'h1, 32'h0);
                end else begin
                    check("b2b_rdata", resp_rdata, exp_rd_q.pop_front());
                    check("b2b_err", 32'(resp_err), 32'(exp_err_q.pop_front()));
                end
            end
        end
        check("b2b_accepts", 32'(n_acc), 32'd4);
        check("b2b_responses", 32'(n_resp), 32'(n_acc));
        check("b2b_word", bmem[16], ref_mem[16]);

        // Random traffic, mostly in a small window so loads observe earlier stores.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(9) == 0) addr = $urandom;
            else                        addr = 32'($urandom_range(255));
            do_req("rand", 1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                   addr, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit between the MEM pipeline stage and the word-wide data memory.
- Accepts byte, halfword and word loads and stores through a valid/ready request, and returns results through a one-cycle response pulse.
- The memory side is word-only: 32-bit combinational read and synchronous word write with write enable. Sub-word stores are therefore done as a read-modify-write sequence.
- Checks alignment and address range before touching memory.

Parameters:
DEPTH_WORDS, 1024, memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.

Ports:
clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: zero-extend (1) or sign-extend (0)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_pc  input  32  PC of the instruction, forwarded to memory
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, out of range or illegal size
mem_addr  output  32  word-aligned byte address to memory
mem_wdata  output  32  word to write
mem_we  output  1  memory write enable
mem_pc  output  32  latched req_pc
mem_rdata  input  32  combinational read data for mem_addr

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_pc=0.
- States: IDLE, LOAD, RMW_READ, WRITE, DONE.
- Accept: handshake occurs when req_valid && req_ready in IDLE. All request fields are latched on that edge.
- Error check on accept. Error if any of:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr >= 4*DEPTH_WORDS
- On error: go to DONE with resp_err=1 and resp_rdata=0. No memory access; mem_we never asserts for the request.
- Next state after accept (no error):
  - load -> LOAD
  - word store -> WRITE
  - byte/half store -> RMW_READ
- mem_addr = {latched_addr[31:2],2'b00} in LOAD, RMW_READ and WRITE; 0 in IDLE and DONE.
- LOAD (1 cycle):
  - Lane select by addr[1:0], little-endian; byte lane k = bits 8k+7:8k.
  - Half lane = addr[1] (0 -> bits 15:0, 1 -> bits 31:16).
  - Extend per req_unsigned and register into resp_rdata; go to DONE.
- RMW_READ (1 cycle): capture mem_rdata into merge register; go to WRITE.
- WRITE (1 cycle):
  - mem_we=1.
  - mem_wdata = req_wdata for word stores; for sub-word stores, the merge register with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - Go to DONE.
- DONE (1 cycle): resp_valid=1; resp_rdata and resp_err held; go to IDLE.
- resp_rdata and resp_err hold their values until the next DONE. resp_rdata is 0 for stores.
- Latency from accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Back-to-back: req_ready rises the cycle after DONE; no overlap of requests.
- mem_we is combinational: (state==WRITE) && !Reset. Reset asserted during WRITE therefore suppresses the write in that cycle.
- Reset in any state returns to IDLE at the next edge with all outputs at reset values. An in-flight request is dropped with no response.
- Requests presented while req_ready=0 are ignored, not queued.
- mem_pc is driven from the latched req_pc whenever the state is not IDLE; it is 0 in IDLE.

Optional Feature:
MAU_TRACE_EN:
- Defined: on each rising clk edge where mem_we=1 and Reset=0, $display "@%h: *%h <= %h" with mem_pc, mem_addr and mem_wdata (the full merged word).
- Undefined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF -> mem_we pulse with mem_addr=0x10 and mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0.
- Memory word 0x10=0xDEADBEEF, LB addr=0x13 signed -> resp_rdata=0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x10 -> 0x0000BEEF.
- Word 0x10=0xDEADBEEF, SB addr=0x11 wdata=0x55 -> RMW read, then write mem_wdata=0xDEAD55EF; resp 3 cycles after accept. Then SH addr=0x12 wdata=0x1234 -> 0x123455EF.
- Misaligned or out-of-range/illegal:
  - LW addr=0x06 -> resp_err=1 after 1 cycle, mem_we never high.
  - SH addr=0x05 -> resp_err=1, no write.
  - SW addr=0x1000 -> resp_err=1, no write.
  - size=11 -> resp_err=1, no write.
- Reset asserted in the cycle the state is WRITE -> mem_we=0 that cycle, no write, no resp_valid, req_ready=1 next cycle.
- req_valid held high for 10 cycles with alternating LW/SW requests -> each accept occurs only when req_ready=1; response count equals accept count; no request lost or duplicated.
